// File: rtl/tc_irq_sched_if.sv
// Interrupt scheduler bus: pending/enable/ack toward the scheduler, and the
// request/vector/clear/busy outputs back out.
interface tc_irq_sched_if #(
    parameter int NSRC = 6
);
    logic [NSRC-1:0] src_pend;
    logic            ie;
    logic            rr_mode;
    logic            interrupt_executed;
    logic            interrupt_request;
    logic [7:0]      vector;
    logic [NSRC-1:0] src_clr;
    logic            busy;

    modport slave (
        input  src_pend,
        input  ie,
        input  rr_mode,
        input  interrupt_executed,
        output interrupt_request,
        output vector,
        output src_clr,
        output busy
    );

    modport master (
        output src_pend,
        output ie,
        output rr_mode,
        output interrupt_executed,
        input  interrupt_request,
        input  vector,
        input  src_clr,
        input  busy
    );
endinterface

// File: rtl/tc_irq_sched.sv
// Timer interrupt scheduler: arbitrates pre-masked timer flags (fixed or
// round-robin), raises one request at a time and pulses the serviced flag clear.
module tc_irq_sched #(
    parameter int         NSRC     = 6,
    parameter logic [7:0] VEC_BASE = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    tc_irq_sched_if.slave irq
);
    localparam int            GW     = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [GW:0]   NSRC_W = NSRC[GW:0];

    typedef enum logic [1:0] {IDLE, REQ, CLR, GAP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   winner;
    logic [NSRC-1:0] clr_d;
    logic [NSRC-1:0] src_clr_q;
    logic            req_q;
    logic [7:0]      vector_q;

    // Search every source once, starting at ptr (round-robin) or at 0 (fixed).
    function automatic logic [GW-1:0] pick_winner(input logic [NSRC-1:0] pend,
                                                  input logic            rr,
                                                  input logic [GW-1:0]   ptr);
        logic [GW-1:0] w;
        logic [GW:0]   sum;
        logic [GW-1:0] idx;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            sum = {1'b0, ptr} + k[GW:0];
            if (sum >= NSRC_W) sum = sum - NSRC_W;
            idx = rr ? sum[GW-1:0] : k[GW-1:0];
            if (!found && pend[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        return ({1'b0, g} == NSRC_W - 1'b1) ? '0 : g + 1'b1;
    endfunction

    assign winner = pick_winner(irq.src_pend, irq.rr_mode, rr_ptr_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        clr_d    = '0;
        case (state_q)
            IDLE: begin
                if (irq.ie && (irq.src_pend != '0)) begin
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over a simultaneous withdraw.
                if (irq.interrupt_executed) begin
                    state_d        = CLR;
                    rr_ptr_d       = next_ptr(grant_q);
                    clr_d[grant_q] = 1'b1;
                end else if (!irq.ie || !irq.src_pend[grant_q]) begin
                    state_d = IDLE;
                end
            end
            CLR:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            req_q     <= 1'b0;
            vector_q  <= VEC_BASE;
            src_clr_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            req_q     <= (state_d == REQ);
            vector_q  <= VEC_BASE + 8'(grant_d);
            src_clr_q <= clr_d;
        end
    end

    assign irq.interrupt_request = req_q;
    assign irq.vector            = vector_q;
    assign irq.src_clr           = src_clr_q;
    assign irq.busy              = (state_q != IDLE);
endmodule

// File: tb/tb_tc_irq_sched.sv
// Directed bench for tc_irq_sched: cycle-level behavioural model compared on
// every falling edge, plus literal expectations for the key scenarios.
module tb_tc_irq_sched;
    localparam int         NSRC     = 6;
    localparam logic [7:0] VEC_BASE = 8'h20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tc_irq_sched_if #(.NSRC(NSRC)) bus ();

    tc_irq_sched #(.NSRC(NSRC), .VEC_BASE(VEC_BASE)) dut (
        .clk (clk),
        .rst (rst),
        .irq (bus)
    );

    always #5 clk = ~clk;

    // Model: "requesting" flag, granted source, rotation pointer and the
    // number of blanking cycles still to run after an acknowledge.
    int         m_req, m_gnt, m_ptr, m_hold;
    logic [7:0] m_vec;
    logic [5:0] m_clr;

    task automatic model_reset();
        m_req  = 0;
        m_gnt  = 0;
        m_ptr  = 0;
        m_hold = 0;
        m_vec  = VEC_BASE;
        m_clr  = '0;
    endtask

    task automatic model_step();
        logic [5:0] p;
        if (!rst) begin
            model_reset();
            return;
        end
        p     = bus.src_pend;
        m_clr = '0;
        if (m_req != 0) begin
            if (bus.interrupt_executed) begin
                m_req  = 0;
                m_clr  = 6'(1 << m_gnt);
                m_ptr  = (m_gnt + 1) % NSRC;
                m_hold = 2;
            end else if (!bus.ie || (((p >> m_gnt) & 6'd1) == 6'd0)) begin
                m_req = 0;
            end
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else if (bus.ie && p != 6'd0) begin
            for (int k = 0; k < NSRC; k++) begin
                int i;
                i = bus.rr_mode ? (m_ptr + k) % NSRC : k;
                if (((p >> i) & 6'd1) != 6'd0) begin
                    m_gnt = i;
                    m_req = 1;
                    break;
                end
            end
            m_vec = 8'((int'(VEC_BASE) + m_gnt) % 256);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("interrupt_request", 32'(bus.interrupt_request), 32'(m_req != 0));
        check("vector", 32'(bus.vector), 32'(m_vec));
        check("src_clr", 32'(bus.src_clr), 32'(m_clr));
        check("busy", 32'(bus.busy), 32'((m_req != 0) || (m_hold > 0)));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] rr_exp [4];
        rr_exp = '{8'h20, 8'h21, 8'h20, 8'h21};
        model_reset();
        bus.src_pend           = '0;
        bus.ie                 = 1'b0;
        bus.rr_mode            = 1'b0;
        bus.interrupt_executed = 1'b0;

        ticks(2);
        check("reset_vector", 32'(bus.vector), 32'h20);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        tick();

        // Fixed priority: lowest index wins, clear pulse, then next source.
        bus.ie = 1'b1;
        bus.src_pend = 6'b010100;
        tick();
        check("fix_req", 32'(bus.interrupt_request), 32'h1);
        check("fix_vec", 32'(bus.vector), 32'h22);
        tick();
        bus.interrupt_executed = 1'b1;
        tick();
        check("fix_clr", 32'(bus.src_clr), 32'h04);
        check("fix_req_low_clr", 32'(bus.interrupt_request), 32'h0);
        bus.interrupt_executed = 1'b0;
        bus.src_pend = 6'b010000;
        tick();
        check("fix_clr_once", 32'(bus.src_clr), 32'h00);
        tick();
        check("fix_gap_req", 32'(bus.interrupt_request), 32'h0);
        tick();
        check("fix_vec2", 32'(bus.vector), 32'h24);
        bus.interrupt_executed = 1'b1;
        tick();
        bus.interrupt_executed = 1'b0;
        bus.src_pend = '0;
        ticks(3);

        // Round-robin with both flags held and never cleared.
        do_reset();
        bus.rr_mode = 1'b1;
        bus.src_pend = 6'b000011;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rr_vec", 32'(bus.vector), 32'(rr_exp[j]));
            bus.interrupt_executed = 1'b1;
            tick();
            bus.interrupt_executed = 1'b0;
            ticks(2);
        end
        bus.src_pend = '0;
        tick();

        // Withdraw: ie drops before ack; pointer must stay at 0.
        do_reset();
        bus.src_pend = 6'b000010;
        tick();
        check("wd_vec", 32'(bus.vector), 32'h21);
        bus.ie = 1'b0;
        tick();
        check("wd_req", 32'(bus.interrupt_request), 32'h0);
        check("wd_clr", 32'(bus.src_clr), 32'h00);
        check("wd_busy", 32'(bus.busy), 32'h0);
        bus.ie = 1'b1;
        bus.src_pend = 6'b000110;
        tick();
        check("wd_ptr_vec", 32'(bus.vector), 32'h21);
        bus.interrupt_executed = 1'b1;
        tick();
        check("wd_ack_clr", 32'(bus.src_clr), 32'h02);
        bus.interrupt_executed = 1'b0;
        bus.src_pend = '0;
        ticks(3);

        // Ack and withdraw together: ack wins. Stray acks are ignored.
        bus.src_pend = 6'b000100;
        tick();
        check("sim_vec", 32'(bus.vector), 32'h22);
        bus.interrupt_executed = 1'b1;
        bus.ie = 1'b0;
        tick();
        check("sim_clr", 32'(bus.src_clr), 32'h04);
        check("sim_busy", 32'(bus.busy), 32'h1);
        bus.ie = 1'b1;
        bus.src_pend = '0;
        tick();
        bus.interrupt_executed = 1'b0;
        tick();
        bus.interrupt_executed = 1'b1;
        tick();
        check("stray_ack_busy", 32'(bus.busy), 32'h0);
        bus.interrupt_executed = 1'b0;

        // No pre-emption while a request is outstanding.
        bus.rr_mode = 1'b0;
        bus.src_pend = 6'b001000;
        tick();
        check("np_vec", 32'(bus.vector), 32'h23);
        bus.src_pend = 6'b001001;
        ticks(2);
        check("np_vec_held", 32'(bus.vector), 32'h23);
        bus.interrupt_executed = 1'b1;
        tick();
        check("np_clr", 32'(bus.src_clr), 32'h08);
        bus.interrupt_executed = 1'b0;
        bus.src_pend = 6'b000001;
        ticks(3);
        check("np_vec_next", 32'(bus.vector), 32'h20);
        bus.interrupt_executed = 1'b1;
        tick();
        bus.interrupt_executed = 1'b0;
        bus.src_pend = '0;
        ticks(3);

        // Asynchronous reset mid-REQ and mid-CLR.
        bus.src_pend = 6'b000010;
        tick();
        check("ar_req_before", 32'(bus.interrupt_request), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("ar_req", 32'(bus.interrupt_request), 32'h0);
        check("ar_clr", 32'(bus.src_clr), 32'h00);
        check("ar_busy", 32'(bus.busy), 32'h0);
        check("ar_vec", 32'(bus.vector), 32'h20);
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        check("ar_restart_vec", 32'(bus.vector), 32'h21);
        bus.interrupt_executed = 1'b1;
        tick();
        bus.interrupt_executed = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("ar_clr_mid", 32'(bus.src_clr), 32'h00);
        check("ar_busy_mid", 32'(bus.busy), 32'h0);
        model_reset();
        tick();
        rst = 1'b1;
        bus.src_pend = '0;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
